alu_rs_sched: RTL and testbench

- Reservation-station scheduler that sits in front of the integer ALU.
- Accepts dispatched arithmetic, branch, jump, LUI and AUIPC micro-ops from the decoder/ROB.
- Holds each op until both operands resolve via CDB wakeup, then issues at most one ready op per cycle to the ALU as a registered inst_valid pulse.
- Flushed by rollback; frozen while rdy is low.

---
 rtl/alu_rs_sched_pkg.sv | 32 +++
 rtl/alu_rs_sched_rs_pick.sv | 52 +++++
 rtl/alu_rs_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_rs_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_sched_pkg.sv
// Shared widths, default sizing and RV32 opcode/func3 constants for the ALU
// reservation-station scheduler.
package alu_rs_sched_pkg;

  localparam int OPCODE_WID  = 7;
  localparam int FUNC3_WID   = 3;
  localparam int DATA_WID    = 32;
  localparam int ROB_ID_WID  = 4;
  localparam int RS_SIZE_DEF = 16;

  localparam logic [OPCODE_WID-1:0] OPC_ARITH   = 7'b0110011;
  localparam logic [OPCODE_WID-1:0] OPC_ARITH_I = 7'b0010011;
  localparam logic [OPCODE_WID-1:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [OPCODE_WID-1:0] OPC_JAL     = 7'b1101111;
  localparam logic [OPCODE_WID-1:0] OPC_JALR    = 7'b1100111;
  localparam logic [OPCODE_WID-1:0] OPC_LUI     = 7'b0110111;
  localparam logic [OPCODE_WID-1:0] OPC_AUIPC   = 7'b0010111;

  localparam logic [FUNC3_WID-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [FUNC3_WID-1:0] F3_SLL     = 3'b001;
  localparam logic [FUNC3_WID-1:0] F3_SLT     = 3'b010;
  localparam logic [FUNC3_WID-1:0] F3_SLTU    = 3'b011;
  localparam logic [FUNC3_WID-1:0] F3_XOR     = 3'b100;
  localparam logic [FUNC3_WID-1:0] F3_SRL_SRA = 3'b101;
  localparam logic [FUNC3_WID-1:0] F3_OR      = 3'b110;
  localparam logic [FUNC3_WID-1:0] F3_AND     = 3'b111;
  localparam logic [FUNC3_WID-1:0] F3_BEQ     = 3'b000;
  localparam logic [FUNC3_WID-1:0] F3_BNE     = 3'b001;
  localparam logic [FUNC3_WID-1:0] F3_BLT     = 3'b100;
  localparam logic [FUNC3_WID-1:0] F3_BGE     = 3'b101;

endpackage

// File: rtl/alu_rs_sched_rs_pick.sv
// rs_pick: selects one requester, lowest index first, or oldest stamp first when
// ALU_RS_AGE_PICK_EN is defined (stamps compared with wrap-around).
module rs_pick #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]           req,
`ifdef ALU_RS_AGE_PICK_EN
  input  logic [N-1:0][IDX_W:0]  stamp,
`endif
  output logic [N-1:0]           grant,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

`ifdef ALU_RS_AGE_PICK_EN
  logic [IDX_W:0] best;
  logic [IDX_W:0] diff;
`endif

  always_comb begin
    any = 1'b0;
    idx = '0;
`ifdef ALU_RS_AGE_PICK_EN
    best = '0;
    diff = '0;
`endif
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
`ifdef ALU_RS_AGE_PICK_EN
        // A negative wrapped difference means stamp[i] was issued before best.
        diff = stamp[i] - best;
        if (!any || diff[IDX_W]) begin
          any  = 1'b1;
          idx  = IDX_W'(i);
          best = stamp[i];
        end
`else
        if (!any) begin
          any = 1'b1;
          idx = IDX_W'(i);
        end
`endif
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant[gi] = any && (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/alu_rs_sched.sv
// alu_rs_sched: reservation station in front of the integer ALU, one issue per cycle.
// Optional build macro ALU_RS_AGE_PICK_EN switches issue order to oldest-first.
module alu_rs_sched
  import alu_rs_sched_pkg::*;
#(
  parameter int RS_SIZE  = RS_SIZE_DEF,
  parameter int ROB_ID_W = ROB_ID_WID,
  parameter int XLEN     = DATA_WID
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  rollback,
  input  logic                  disp_valid,
  input  logic [OPCODE_WID-1:0] disp_opcode,
  input  logic [FUNC3_WID-1:0]  disp_func3,
  input  logic                  disp_func1,
  input  logic                  disp_qj_valid,
  input  logic                  disp_qk_valid,
  input  logic [ROB_ID_W-1:0]   disp_qj,
  input  logic [ROB_ID_W-1:0]   disp_qk,
  input  logic [XLEN-1:0]       disp_vj,
  input  logic [XLEN-1:0]       disp_vk,
  input  logic [XLEN-1:0]       disp_imm,
  input  logic [XLEN-1:0]       disp_off,
  input  logic [XLEN-1:0]       disp_pc,
  input  logic [ROB_ID_W-1:0]   disp_rob,
  input  logic                  disp_c_ext,
  output logic                  full,
  input  logic                  cdb_alu_valid,
  input  logic                  cdb_lsb_valid,
  input  logic [ROB_ID_W-1:0]   cdb_alu_rob,
  input  logic [ROB_ID_W-1:0]   cdb_lsb_rob,
  input  logic [XLEN-1:0]       cdb_alu_data,
  input  logic [XLEN-1:0]       cdb_lsb_data,
  output logic                  alu_inst_valid,
  output logic [OPCODE_WID-1:0] alu_opcode,
  output logic [FUNC3_WID-1:0]  alu_func3,
  output logic                  alu_func1,
  output logic [XLEN-1:0]       alu_data1,
  output logic [XLEN-1:0]       alu_data2,
  output logic [XLEN-1:0]       alu_imm,
  output logic [XLEN-1:0]       alu_off,
  output logic [XLEN-1:0]       alu_pc,
  output logic [ROB_ID_W-1:0]   alu_rob_target,
  output logic                  alu_c_ext
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;
  // Operand-independent fields travel together as one packed payload word.
  localparam int PAY_W = OPCODE_WID + FUNC3_WID + 2 + 3 * XLEN + ROB_ID_W;

  logic [RS_SIZE-1:0]  busy_q, busy_d, qj_pend_q, qj_pend_d, qk_pend_q, qk_pend_d;
  logic [ROB_ID_W-1:0] qj_q [RS_SIZE];
  logic [ROB_ID_W-1:0] qj_d [RS_SIZE];
  logic [ROB_ID_W-1:0] qk_q [RS_SIZE];
  logic [ROB_ID_W-1:0] qk_d [RS_SIZE];
  logic [XLEN-1:0]     vj_q [RS_SIZE];
  logic [XLEN-1:0]     vj_d [RS_SIZE];
  logic [XLEN-1:0]     vk_q [RS_SIZE];
  logic [XLEN-1:0]     vk_d [RS_SIZE];
  logic [PAY_W-1:0]    pay_q [RS_SIZE];
  logic [PAY_W-1:0]    pay_d [RS_SIZE];

  logic                alu_valid_q, alu_valid_d, full_q, full_d;
  logic [PAY_W-1:0]    alu_pay_q, alu_pay_d, disp_pay;
  logic [XLEN-1:0]     alu_data1_q, alu_data1_d, alu_data2_q, alu_data2_d;
  logic [CNT_W-1:0]    busy_cnt;

  logic [RS_SIZE-1:0]  eligible, issue_grant, free_grant;
  logic [IDX_W-1:0]    issue_idx, free_idx;
  logic                issue_any, free_any;

`ifdef ALU_RS_AGE_PICK_EN
  logic [RS_SIZE-1:0][IDX_W:0] stamp_q, stamp_d;
  logic [IDX_W:0]              seq_q, seq_d;
`endif

  assign disp_pay = {disp_opcode, disp_func3, disp_func1, disp_imm, disp_off, disp_pc,
                     disp_rob, disp_c_ext};
  assign {alu_opcode, alu_func3, alu_func1, alu_imm, alu_off, alu_pc, alu_rob_target,
          alu_c_ext} = alu_pay_q;
  assign alu_inst_valid = alu_valid_q;
  assign alu_data1      = alu_data1_q;
  assign alu_data2      = alu_data2_q;
  assign full           = full_q;

  // Eligibility uses registered pending bits, so a wakeup issues one cycle later.
  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_elig
    assign eligible[gi] = busy_q[gi] && !qj_pend_q[gi] && !qk_pend_q[gi];
  end

  rs_pick #(.N(RS_SIZE)) u_issue_pick (
    .req   (eligible),
`ifdef ALU_RS_AGE_PICK_EN
    .stamp (stamp_q),
`endif
    .grant (issue_grant),
    .idx   (issue_idx),
    .any   (issue_any)
  );

  rs_pick #(.N(RS_SIZE)) u_free_pick (
    .req   (~busy_q),
`ifdef ALU_RS_AGE_PICK_EN
    .stamp ('0),
`endif
    .grant (free_grant),
    .idx   (free_idx),
    .any   (free_any)
  );

  // Returns {still_pending, value}; the ALU broadcast takes precedence over the LSB one.
  function automatic logic [XLEN:0] capture(input logic pend, input logic [ROB_ID_W-1:0] tag,
                                            input logic [XLEN-1:0] val);
    if (pend && cdb_alu_valid && (cdb_alu_rob == tag)) return {1'b0, cdb_alu_data};
    if (pend && cdb_lsb_valid && (cdb_lsb_rob == tag)) return {1'b0, cdb_lsb_data};
    return {pend, val};
  endfunction

  always_comb begin
    busy_d      = busy_q;
    qj_pend_d   = qj_pend_q;
    qk_pend_d   = qk_pend_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    pay_d       = pay_q;
    alu_valid_d = alu_valid_q;
    alu_pay_d   = alu_pay_q;
    alu_data1_d = alu_data1_q;
    alu_data2_d = alu_data2_q;
    full_d      = full_q;
    busy_cnt    = '0;
`ifdef ALU_RS_AGE_PICK_EN
    stamp_d     = stamp_q;
    seq_d       = seq_q;
`endif
    if (rollback) begin
      busy_d      = '0;
      full_d      = 1'b0;
      alu_valid_d = 1'b0;
      alu_pay_d   = '0;
      alu_data1_d = '0;
      alu_data2_d = '0;
`ifdef ALU_RS_AGE_PICK_EN
      seq_d       = '0;
`endif
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          {qj_pend_d[i], vj_d[i]} = capture(qj_pend_q[i], qj_q[i], vj_q[i]);
          {qk_pend_d[i], vk_d[i]} = capture(qk_pend_q[i], qk_q[i], vk_q[i]);
        end
      end
      alu_valid_d = issue_any;
      if (issue_any) begin
        alu_pay_d   = pay_q[issue_idx];
        alu_data1_d = vj_q[issue_idx];
        alu_data2_d = vk_q[issue_idx];
      end
      busy_d = busy_d & ~issue_grant;
      // The free slot was idle before this edge, so it can never be the issuing entry.
      if (disp_valid && free_any) begin
        busy_d          = busy_d | free_grant;
        pay_d[free_idx] = disp_pay;
        qj_d[free_idx]  = disp_qj;
        qk_d[free_idx]  = disp_qk;
        {qj_pend_d[free_idx], vj_d[free_idx]} = capture(disp_qj_valid, disp_qj, disp_vj);
        {qk_pend_d[free_idx], vk_d[free_idx]} = capture(disp_qk_valid, disp_qk, disp_vk);
`ifdef ALU_RS_AGE_PICK_EN
        stamp_d[free_idx] = seq_q;
        seq_d             = seq_q + 1'b1;
`endif
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        busy_cnt = busy_cnt + CNT_W'(busy_d[i]);
      end
      full_d = (busy_cnt >= CNT_W'(RS_SIZE - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      qj_pend_q   <= '0;
      qk_pend_q   <= '0;
      qj_q        <= '{default: '0};
      qk_q        <= '{default: '0};
      vj_q        <= '{default: '0};
      vk_q        <= '{default: '0};
      pay_q       <= '{default: '0};
      alu_valid_q <= 1'b0;
      alu_pay_q   <= '0;
      alu_data1_q <= '0;
      alu_data2_q <= '0;
      full_q      <= 1'b0;
`ifdef ALU_RS_AGE_PICK_EN
      stamp_q     <= '0;
      seq_q       <= '0;
`endif
    end else begin
      busy_q      <= busy_d;
      qj_pend_q   <= qj_pend_d;
      qk_pend_q   <= qk_pend_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      pay_q       <= pay_d;
      alu_valid_q <= alu_valid_d;
      alu_pay_q   <= alu_pay_d;
      alu_data1_q <= alu_data1_d;
      alu_data2_q <= alu_data2_d;
      full_q      <= full_d;
`ifdef ALU_RS_AGE_PICK_EN
      stamp_q     <= stamp_d;
      seq_q       <= seq_d;
`endif
    end
  end

  a_disp_needs_free: assert property (@(posedge clk) disable iff (!rst_n)
    (rdy && !rollback && disp_valid) |-> free_any)
    else $error("dispatch with no free reservation-station entry");

endmodule

// File: tb/tb_alu_rs_sched.sv
// Directed bench for alu_rs_sched: latency, wakeup, capture-on-dispatch, fill/full,
// rdy hold, rollback, async reset and issue ordering (both pick modes).
module tb_alu_rs_sched;
  import alu_rs_sched_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n, rdy, rollback;
  logic                  disp_valid, disp_func1, disp_qj_valid, disp_qk_valid, disp_c_ext;
  logic [OPCODE_WID-1:0] disp_opcode;
  logic [FUNC3_WID-1:0]  disp_func3;
  logic [ROB_ID_WID-1:0] disp_qj, disp_qk, disp_rob;
  logic [DATA_WID-1:0]   disp_vj, disp_vk, disp_imm, disp_off, disp_pc;
  logic                  full;
  logic                  cdb_alu_valid, cdb_lsb_valid;
  logic [ROB_ID_WID-1:0] cdb_alu_rob, cdb_lsb_rob;
  logic [DATA_WID-1:0]   cdb_alu_data, cdb_lsb_data;
  logic                  alu_inst_valid, alu_func1, alu_c_ext;
  logic [OPCODE_WID-1:0] alu_opcode;
  logic [FUNC3_WID-1:0]  alu_func3;
  logic [DATA_WID-1:0]   alu_data1, alu_data2, alu_imm, alu_off, alu_pc;
  logic [ROB_ID_WID-1:0] alu_rob_target;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_rs_sched dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .disp_valid(disp_valid), .disp_opcode(disp_opcode), .disp_func3(disp_func3),
    .disp_func1(disp_func1), .disp_qj_valid(disp_qj_valid), .disp_qk_valid(disp_qk_valid),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_imm(disp_imm), .disp_off(disp_off), .disp_pc(disp_pc), .disp_rob(disp_rob),
    .disp_c_ext(disp_c_ext), .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_lsb_valid(cdb_lsb_valid),
    .cdb_alu_rob(cdb_alu_rob), .cdb_lsb_rob(cdb_lsb_rob),
    .cdb_alu_data(cdb_alu_data), .cdb_lsb_data(cdb_lsb_data),
    .alu_inst_valid(alu_inst_valid), .alu_opcode(alu_opcode), .alu_func3(alu_func3),
    .alu_func1(alu_func1), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_imm(alu_imm), .alu_off(alu_off), .alu_pc(alu_pc),
    .alu_rob_target(alu_rob_target), .alu_c_ext(alu_c_ext)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb_clear();
    cdb_alu_valid = 1'b0; cdb_alu_rob = '0; cdb_alu_data = '0;
    cdb_lsb_valid = 1'b0; cdb_lsb_rob = '0; cdb_lsb_data = '0;
  endtask

  task automatic drive_disp(input logic [6:0] op, input logic qjv, input logic [3:0] qj,
                            input logic [31:0] vj, input logic qkv, input logic [3:0] qk,
                            input logic [31:0] vk, input logic [3:0] rob);
    disp_valid = 1'b1; disp_opcode = op; disp_func3 = F3_ADD_SUB; disp_func1 = 1'b0;
    disp_qj_valid = qjv; disp_qj = qj; disp_vj = vj;
    disp_qk_valid = qkv; disp_qk = qk; disp_vk = vk;
    disp_imm = 32'h100 + 32'(rob); disp_off = 32'h4; disp_pc = 32'h1000 + 32'(rob);
    disp_rob = rob; disp_c_ext = 1'b0;
    $display("disp rob=%0d op=%02h qj=%0b/%0d vj=%0h qk=%0b/%0d vk=%0h rdy=%0b",
             rob, op, qjv, qj, vj, qkv, qk, vk, rdy);
  endtask

  task automatic dispatch(input logic [6:0] op, input logic qjv, input logic [3:0] qj,
                          input logic [31:0] vj, input logic qkv, input logic [3:0] qk,
                          input logic [31:0] vk, input logic [3:0] rob);
    drive_disp(op, qjv, qj, vj, qkv, qk, vk, rob);
    tick();
    disp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0;
    disp_valid = 1'b0; disp_opcode = '0; disp_func3 = '0; disp_func1 = 1'b0;
    disp_qj_valid = 1'b0; disp_qk_valid = 1'b0; disp_qj = '0; disp_qk = '0;
    disp_vj = '0; disp_vk = '0; disp_imm = '0; disp_off = '0; disp_pc = '0;
    disp_rob = '0; disp_c_ext = 1'b0;
    cdb_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", alu_inst_valid, 0);
    check("rst_full", full, 0);
    check("rst_data1", alu_data1, 0);
    rst_n = 1'b1;

    // Ready ADD: issue pulse one edge after the entry is written, then drops.
    dispatch(OPC_ARITH, 0, 0, 5, 0, 0, 7, 3);
    check("add_lat0", alu_inst_valid, 0);
    tick();
    check("add_valid", alu_inst_valid, 1);
    check("add_data1", alu_data1, 5);
    check("add_data2", alu_data2, 7);
    check("add_rob", alu_rob_target, 3);
    check("add_opcode", alu_opcode, OPC_ARITH);
    check("add_imm", alu_imm, 32'h103);
    check("add_pc", alu_pc, 32'h1003);
    tick();
    check("add_drop", alu_inst_valid, 0);
    check("add_hold", alu_data1, 5);

    // Wakeup via ALU CDB; no issue on the wake edge itself.
    dispatch(OPC_ARITH, 1, 2, 0, 0, 0, 1, 4);
    check("wk_pend0", alu_inst_valid, 0);
    tick();
    check("wk_pend1", alu_inst_valid, 0);
    cdb_alu_valid = 1'b1; cdb_alu_rob = 2; cdb_alu_data = 32'h10;
    tick();
    cdb_clear();
    check("wk_same", alu_inst_valid, 0);
    tick();
    check("wk_valid", alu_inst_valid, 1);
    check("wk_data1", alu_data1, 32'h10);
    check("wk_data2", alu_data2, 1);
    check("wk_rob", alu_rob_target, 4);
    tick();

    // Capture-on-dispatch from the LSB CDB.
    cdb_lsb_valid = 1'b1; cdb_lsb_rob = 6; cdb_lsb_data = 32'hAB;
    dispatch(OPC_BRANCH, 0, 0, 9, 1, 6, 0, 5);
    cdb_clear();
    check("cap_lat0", alu_inst_valid, 0);
    tick();
    check("cap_valid", alu_inst_valid, 1);
    check("cap_data2", alu_data2, 32'hAB);
    check("cap_data1", alu_data1, 9);
    tick();

    // Both CDBs carry the pending tag: ALU data wins.
    cdb_alu_valid = 1'b1; cdb_alu_rob = 7; cdb_alu_data = 32'h11;
    cdb_lsb_valid = 1'b1; cdb_lsb_rob = 7; cdb_lsb_data = 32'h22;
    dispatch(OPC_LUI, 1, 7, 0, 0, 0, 0, 6);
    cdb_clear();
    tick();
    check("both_valid", alu_inst_valid, 1);
    check("both_data1", alu_data1, 32'h11);
    tick();

    // rdy low: dispatch ignored; a held issue pulse stays put.
    rdy = 1'b0;
    dispatch(OPC_ARITH, 0, 0, 1, 0, 0, 1, 1);
    rdy = 1'b1;
    tick();
    check("rdy_ignored", alu_inst_valid, 0);
    dispatch(OPC_ARITH, 0, 0, 3, 0, 0, 4, 2);
    tick();
    check("rdy_iss", alu_inst_valid, 1);
    rdy = 1'b0;
    tick();
    check("rdy_hold_v", alu_inst_valid, 1);
    check("rdy_hold_rob", alu_rob_target, 2);
    rdy = 1'b1;
    tick();
    check("rdy_drop", alu_inst_valid, 0);

    // Fill 15 pending entries, then release them all with one broadcast.
    for (int i = 0; i < 15; i++) begin
      dispatch(OPC_ARITH, 1, 9, 0, 0, 0, 32'(i), 4'(i));
      if (i == 13) check("fill_full14", full, 0);
    end
    check("fill_full15", full, 1);
    cdb_alu_valid = 1'b1; cdb_alu_rob = 9; cdb_alu_data = 32'h55;
    tick();
    cdb_clear();
    check("fill_wake", alu_inst_valid, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("fill_iss_v", alu_inst_valid, 1);
      check("fill_iss_rob", alu_rob_target, i);
      check("fill_iss_d2", alu_data2, i);
      if (i == 0) begin
        check("fill_iss_d1", alu_data1, 32'h55);
        check("fill_full_drop", full, 0);
      end
    end
    tick();
    check("fill_done", alu_inst_valid, 0);

    // Rollback with the station full and an issue pulse on the wire.
    for (int i = 0; i < 15; i++) dispatch(OPC_ARITH, 1, 12, 0, 0, 0, 0, 4'(i));
    dispatch(OPC_AUIPC, 0, 0, 32'h77, 0, 0, 0, 15);
    check("rb_full16", full, 1);
    tick();
    check("rb_pre_v", alu_inst_valid, 1);
    check("rb_pre_rob", alu_rob_target, 15);
    check("rb_pre_full", full, 1);
    rollback = 1'b1;
    drive_disp(OPC_ARITH, 0, 0, 32'h33, 0, 0, 0, 8);
    tick();
    rollback = 1'b0; disp_valid = 1'b0;
    check("rb_valid", alu_inst_valid, 0);
    check("rb_full", full, 0);
    check("rb_data1", alu_data1, 0);
    check("rb_rob", alu_rob_target, 0);
    cdb_alu_valid = 1'b1; cdb_alu_rob = 12; cdb_alu_data = 32'h1;
    tick();
    cdb_clear();
    tick();
    check("rb_quiet1", alu_inst_valid, 0);
    tick();
    check("rb_quiet2", alu_inst_valid, 0);

    // Asynchronous reset between edges.
    dispatch(OPC_ARITH, 1, 11, 0, 0, 0, 0, 1);
    dispatch(OPC_ARITH, 1, 11, 0, 0, 0, 0, 2);
    dispatch(OPC_JAL, 0, 0, 32'h99, 0, 0, 0, 3);
    tick();
    check("ar_pre_v", alu_inst_valid, 1);
    check("ar_pre_d1", alu_data1, 32'h99);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", alu_inst_valid, 0);
    check("ar_data1", alu_data1, 0);
    check("ar_rob", alu_rob_target, 0);
    #1 rst_n = 1'b1;
    cdb_alu_valid = 1'b1; cdb_alu_rob = 11; cdb_alu_data = 32'h2;
    tick();
    cdb_clear();
    tick();
    check("ar_quiet1", alu_inst_valid, 0);
    tick();
    check("ar_quiet2", alu_inst_valid, 0);

    // Ordering: index 5 (older) and index 1 (younger) become ready together.
    dispatch(OPC_ARITH, 1, 13, 0, 0, 0, 0, 0);
    dispatch(OPC_ARITH, 1, 14, 0, 0, 0, 0, 1);
    dispatch(OPC_ARITH, 1, 13, 0, 0, 0, 0, 2);
    dispatch(OPC_ARITH, 1, 13, 0, 0, 0, 0, 3);
    dispatch(OPC_ARITH, 1, 13, 0, 0, 0, 0, 4);
    dispatch(OPC_ARITH, 1, 15, 0, 0, 0, 0, 5);
    cdb_alu_valid = 1'b1; cdb_alu_rob = 14; cdb_alu_data = 32'h1;
    tick();
    cdb_clear();
    tick();
    check("age_free1_rob", alu_rob_target, 1);
    dispatch(OPC_ARITH, 1, 15, 0, 0, 0, 0, 9);
    cdb_alu_valid = 1'b1; cdb_alu_rob = 15; cdb_alu_data = 32'h3;
    tick();
    cdb_clear();
    tick();
    check("age_first_v", alu_inst_valid, 1);
`ifdef ALU_RS_AGE_PICK_EN
    check("age_first_rob", alu_rob_target, 5);
`else
    check("age_first_rob", alu_rob_target, 9);
`endif
    tick();
    check("age_second_v", alu_inst_valid, 1);
`ifdef ALU_RS_AGE_PICK_EN
    check("age_second_rob", alu_rob_target, 9);
`else
    check("age_second_rob", alu_rob_target, 5);
`endif
    tick();
    check("age_done", alu_inst_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
